// File: rtl/cp0_ctrl_pkg.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : cp0_ctrl_pkg
//  Brief    : Shared types and constants for the CP0 sequencing controller:
//             FSM state encoding, CP0 register numbers, default vector.
//  Revision : 1.0 - initial release
// ============================================================================
package cp0_ctrl_pkg;

  // Sequencer states; IDLE must be the reset encoding.
  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_INT_SAVE = 3'd1,
    ST_INT_VEC  = 3'd2,
    ST_ERET_CLR = 3'd3,
    ST_ERET_JMP = 3'd4,
    ST_MTC0_WR  = 3'd5,
    ST_MFC0_RD  = 3'd6
  } state_e;

  // CP0 register numbers as encoded in instruction bits [15:11].
  localparam logic [4:0] SEL_SR    = 5'd12;
  localparam logic [4:0] SEL_CAUSE = 5'd13;
  localparam logic [4:0] SEL_EPC   = 5'd14;
  localparam logic [4:0] SEL_PRID  = 5'd15;

  // Default interrupt handler entry (byte address).
  localparam logic [31:0] VECTOR_ADDR_DEFAULT = 32'h0000_4180;

endpackage : cp0_ctrl_pkg
`default_nettype wire

// File: rtl/cp0_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : cp0_ctrl
//  Brief    : CP0 sequencing controller for the multicycle MIPS core.
//             Samples each instruction at issue and runs interrupt entry,
//             ERET return, MTC0 write or MFC0 read; stalls the core while
//             busy and redirects the PC for interrupt/ERET.
//  Options  : define CP0_CTRL_INTCNT_EN to add a saturating int_count output
//             (width CNT_W) counting committed interrupt entries.
//  Revision : 1.0 - initial release
// ============================================================================
module cp0_ctrl
  import cp0_ctrl_pkg::*;
#(
  parameter logic [31:0] VECTOR_ADDR = VECTOR_ADDR_DEFAULT
`ifdef CP0_CTRL_INTCNT_EN
  ,parameter int unsigned CNT_W = 16
`endif
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        issue,
  input  logic        is_eret,
  input  logic        is_mtc0,
  input  logic        is_mfc0,
  input  logic [4:0]  rd_sel,
  input  logic        int_req,
  input  logic [29:0] epc_in,
  output logic        cp0_wen,
  output logic        cp0_exlset,
  output logic        cp0_exlclr,
  output logic [4:0]  cp0_sel,
  output logic        stall,
  output logic        pc_redirect,
  output logic [29:0] pc_target,
  output logic        mfc0_valid,
  output logic        int_taken
`ifdef CP0_CTRL_INTCNT_EN
  ,output logic [CNT_W-1:0] int_count
`endif
);

  // Handler vector as a word address; byte-offset bits are dropped.
  localparam logic [29:0] VEC_WORD = VECTOR_ADDR[31:2];

  state_e     state_q, state_d;
  logic [4:0] sel_q,   sel_d;

  // State and latched register-select storage.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      sel_q   <= 5'd0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
    end
  end

  // Next-state decode; an issue is only honoured in IDLE, interrupt wins.
  always_comb begin
    state_d = ST_IDLE;
    sel_d   = sel_q;
    unique case (state_q)
      ST_IDLE: begin
        state_d = ST_IDLE;
        if (issue) begin
          sel_d = rd_sel;
          if (int_req)      state_d = ST_INT_SAVE;
          else if (is_eret) state_d = ST_ERET_CLR;
          else if (is_mtc0) state_d = ST_MTC0_WR;
          else if (is_mfc0) state_d = ST_MFC0_RD;
          else              state_d = ST_IDLE;
        end
      end
      ST_INT_SAVE: state_d = ST_INT_VEC;
      ST_ERET_CLR: state_d = ST_ERET_JMP;
      default:     state_d = ST_IDLE;
    endcase
  end

  // Moore output decode; sel 0 in the EXL-update states means no GPR data.
  always_comb begin
    cp0_wen     = 1'b0;
    cp0_exlset  = 1'b0;
    cp0_exlclr  = 1'b0;
    cp0_sel     = 5'd0;
    stall       = (state_q != ST_IDLE);
    pc_redirect = 1'b0;
    pc_target   = 30'd0;
    mfc0_valid  = 1'b0;
    int_taken   = 1'b0;
    unique case (state_q)
      ST_INT_SAVE: begin
        cp0_wen    = 1'b1;
        cp0_exlset = 1'b1;
      end
      ST_INT_VEC: begin
        pc_redirect = 1'b1;
        pc_target   = VEC_WORD;
        int_taken   = 1'b1;
      end
      ST_ERET_CLR: begin
        cp0_wen    = 1'b1;
        cp0_exlclr = 1'b1;
      end
      ST_ERET_JMP: begin
        pc_redirect = 1'b1;
        pc_target   = epc_in;
      end
      ST_MTC0_WR: begin
        cp0_wen = 1'b1;
        cp0_sel = sel_q;
      end
      ST_MFC0_RD: begin
        cp0_sel    = sel_q;
        mfc0_valid = 1'b1;
      end
      default: ;
    endcase
  end

`ifdef CP0_CTRL_INTCNT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Saturating count of committed interrupt entries.
  always_comb begin
    cnt_d = cnt_q;
    if (int_taken && (cnt_q != {CNT_W{1'b1}})) cnt_d = cnt_q + 1'b1;
  end

  // Counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign int_count = cnt_q;
`endif

endmodule : cp0_ctrl
`default_nettype wire

// File: doc/cp0_ctrl.md
Name: cp0_ctrl

Overview:
Sequencing controller for the coprocessor-0 register file in the multicycle MIPS core. Samples each instruction at its issue boundary and decides between normal CP0 access (MTC0/MFC0), interrupt entry and ERET return. Generates the CP0 write-enable, EXL set/clear and select strobes, stalls the core while sequencing, and redirects the PC to the handler vector or the saved EPC.

Parameters:
VECTOR_ADDR, 32'h0000_4180, interrupt handler entry address; bits [1:0] ignored.
CNT_W, 16, width of the optional interrupt counter.

Ports:
clk  in  1  core clock
rst  in  1  reset; asynchronous, active-high
issue  in  1  one-cycle pulse: the decoded instruction is ready to execute
is_eret  in  1  decoded instruction is ERET; valid with issue
is_mtc0  in  1  decoded instruction is MTC0; valid with issue
is_mfc0  in  1  decoded instruction is MFC0; valid with issue
rd_sel  in  5  CP0 register number from instruction [15:11]; valid with issue
int_req  in  1  CP0 interrupt request (already masked by IM/IE/EXL)
epc_in  in  30  CP0 EPC, word address [31:2]
cp0_wen  out  1  CP0 write/update strobe
cp0_exlset  out  1  set EXL; qualified by cp0_wen
cp0_exlclr  out  1  clear EXL; qualified by cp0_wen
cp0_sel  out  5  CP0 register select
stall  out  1  core must hold the PC and must not issue
pc_redirect  out  1  one-cycle pulse: load pc_target into the PC
pc_target  out  30  redirect word address
mfc0_valid  out  1  one-cycle pulse: CP0 read data is valid for GPR write-back
int_taken  out  1  one-cycle pulse: interrupt entry committed

Behaviour:
- Reset: state IDLE; all outputs 0; cp0_sel 0; pc_target 0. Reset mid-sequence aborts to IDLE with no redirect.
- States: IDLE, INT_SAVE, INT_VEC, ERET_CLR, ERET_JMP, MTC0_WR, MFC0_RD.
- IDLE, issue=1, decision priority: int_req -> INT_SAVE; else is_eret -> ERET_CLR; else is_mtc0 -> MTC0_WR; else is_mfc0 -> MFC0_RD; else stay in IDLE. issue with no flag set and int_req=0 is a no-op. The rd_sel value is latched at issue.
- INT_SAVE: cp0_wen=1, cp0_exlset=1, cp0_sel=0 (no register write). The issuing instruction is squashed; CP0 captures its PC as EPC. Next state INT_VEC.
- INT_VEC: pc_redirect=1, pc_target=VECTOR_ADDR[31:2], int_taken=1. Next state IDLE.
- ERET_CLR: cp0_wen=1, cp0_exlclr=1, cp0_sel=0. Next state ERET_JMP.
- ERET_JMP: pc_redirect=1, pc_target=epc_in (sampled this cycle). Next state IDLE.
- MTC0_WR: cp0_wen=1, cp0_sel=latched rd_sel. Next state IDLE.
- MFC0_RD: cp0_sel=latched rd_sel, mfc0_valid=1, cp0_wen=0. Next state IDLE.
- Outputs are decoded from the state (Moore). stall=1 in every state other than IDLE. Latency from issue to redirect is 2 cycles for both interrupt entry and ERET. MTC0 and MFC0 each cost 1 cycle.
- issue while not in IDLE is illegal and is ignored. The bench asserts it never occurs.
- int_req asserted outside an issue cycle is ignored until the next issue. Interrupts are taken only at instruction boundaries.
- cp0_exlset and cp0_exlclr are never both 1.

Optional Feature:
CP0_CTRL_INTCNT_EN: adds output int_count [CNT_W-1:0]. It increments on every int_taken and saturates at all-ones. It clears on rst. Without the macro, the port and the counter are absent and all other behaviour is identical.

Decomposition:
- Package cp0_ctrl_pkg holds:
  - the state enum;
  - CP0 register numbers SEL_SR=12, SEL_CAUSE=13, SEL_EPC=14, SEL_PRID=15;
  - the default vector constant.
- Single module. No sub-module is warranted; the FSM and the optional counter both sit in cp0_ctrl.

Test Plan:
- MTC0 $12: issue, is_mtc0=1, rd_sel=12 -> next cycle cp0_wen=1, cp0_sel=12, stall=1 for exactly 1 cycle, no redirect.
- MFC0 $15: issue, is_mfc0=1, rd_sel=15 -> next cycle cp0_sel=15, mfc0_valid=1, cp0_wen=0.
- Interrupt: issue with int_req=1 and is_mtc0=1 -> INT_SAVE (wen=1, exlset=1, sel=0), then INT_VEC (pc_redirect=1, pc_target=30'h0000_1060, int_taken=1). The MTC0 write never occurs.
- ERET: epc_in=30'h0000_0C05, issue with is_eret=1 -> ERET_CLR (wen=1, exlclr=1), then pc_redirect=1, pc_target=30'h0000_0C05. stall=1 for 2 cycles.
- Reset mid-op: assert rst during INT_SAVE -> all outputs 0 immediately; after release, IDLE with no pc_redirect pulse.
- With CP0_CTRL_INTCNT_EN and CNT_W=2: take 5 interrupts -> int_count reads 1, 2, 3, 3, 3.
